// File: rtl/axi_stream_fifo.sv
// Synchronous first-word-fall-through AXI-stream FIFO carrying data/user/dest/tlast per beat.
// Optional store-and-forward packet mode is enabled by defining AXIS_FIFO_PACKET_MODE_EN.
module axi_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEST_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [USER_WIDTH-1:0]   in_user,
  input  logic [DEST_WIDTH-1:0]   in_dest,
  input  logic                    in_valid,
  input  logic                    in_tlast,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [USER_WIDTH-1:0]   out_user,
  output logic [DEST_WIDTH-1:0]   out_dest,
  output logic                    out_valid,
  output logic                    out_tlast,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = DATA_WIDTH + USER_WIDTH + DEST_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [BW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;
  logic            is_full, is_empty;
  logic [BW-1:0]   head;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign head     = mem[rd_ptr_q];

  // in_ready comes straight from a flop; reset only masks it while asserted.
  assign in_ready = in_ready_q && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          release_q, release_d;
  logic          pkt_in, pkt_out;

  assign pkt_in  = push && in_tlast;
  assign pkt_out = pop && out_tlast;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (pkt_in && !pkt_out) begin
      pkt_count_d = pkt_count_q + 1'b1;
    end else if (!pkt_in && pkt_out) begin
      pkt_count_d = pkt_count_q - 1'b1;
    end
    // A full FIFO with no complete packet would deadlock, so it releases beats
    // until the partial packet ends or the FIFO runs dry.
    release_d = release_q;
    if (is_full) begin
      release_d = 1'b1;
    end
    if (pkt_out || count_d == '0) begin
      release_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_q <= '0;
      release_q   <= 1'b0;
    end else begin
      pkt_count_q <= pkt_count_d;
      release_q   <= release_d;
    end
  end

  assign out_valid = !reset && !is_empty && (pkt_count_q != '0 || is_full || release_q);
`else
  assign out_valid = !reset && !is_empty;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_tlast, in_dest, in_user, in_data};
    end
  end

  always_comb begin
    {out_tlast, out_dest, out_user, out_data} = '0;
    if (!reset && !is_empty) begin
      {out_tlast, out_dest, out_user, out_data} = head;
    end
  end

  assign fill_level = reset ? '0 : count_q;
  assign full       = !reset && is_full;
  assign empty      = reset || is_empty;

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Directed bench for axi_stream_fifo; packet-mode scenarios run when AXIS_FIFO_PACKET_MODE_EN is defined.
module tb_axi_stream_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int BW = 3 * DW + 1;
`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data, in_user, in_dest;
  logic          in_valid, in_tlast, in_ready;
  logic [DW-1:0] out_data, out_user, out_dest;
  logic          out_valid, out_tlast, out_ready;
  logic [4:0]    fill_level;
  logic          full, empty;

  int tests_run = 0;
  int tests_failed = 0;

  axi_stream_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(DW), .DEST_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_user(in_user), .in_dest(in_dest),
    .in_valid(in_valid), .in_tlast(in_tlast), .in_ready(in_ready),
    .out_data(out_data), .out_user(out_user), .out_dest(out_dest),
    .out_valid(out_valid), .out_tlast(out_tlast), .out_ready(out_ready),
    .fill_level(fill_level), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [BW-1:0] beat(input logic [DW-1:0] d, input logic t);
    return {t, d + 32'h1000, ~d, d};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic t);
    in_valid = v;
    in_data  = d;
    in_user  = ~d;
    in_dest  = d + 32'h1000;
    in_tlast = t;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BW-1:0] out_beat();
    return {out_tlast, out_dest, out_user, out_data};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0);

    // 1: reset state, FWFT, basic push
    tick();
    @(negedge clock);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_fill", fill_level, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_in_ready", in_ready, 1);
    tick();
    drive(1'b1, 32'h11, 1'b1);
    tick();
    drive(1'b1, 32'h22, 1'b1);
    @(negedge clock);
    check_eq("fwft_valid", out_valid, 1);
    check_eq("fwft_data", out_data, 32'h11);
    tick();
    drive(1'b1, 32'h33, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t1_fill", fill_level, 3);
    check_eq("t1_head", out_data, 32'h11);
    check_eq("t1_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("t1_pop%0d", i), out_beat(), beat(32'h11 * (i + 1), 1'b1));
      tick();
    end
    @(negedge clock);
    check_eq("t1_empty", empty, 1);
    check_eq("t1_out_data_zero", out_data, 0);

    // 2: fill to DEPTH, overflow beat refused, drain in order
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, (i % 4) == 3);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t2_full", full, 1);
    check_eq("t2_in_ready", in_ready, 0);
    check_eq("t2_fill", fill_level, DEPTH);
    tick();
    drive(1'b1, 32'hDEAD, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t2_fill_after_17th", fill_level, DEPTH);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      check_eq($sformatf("t2_pop%0d", i), out_beat(), beat(i, (i % 4) == 3));
      if (i == 0) check_eq("t2_ready_same_cycle", in_ready, 0);
      if (i == 1) check_eq("t2_ready_next_cycle", in_ready, 1);
      tick();
    end
    @(negedge clock);
    check_eq("t2_empty", empty, 1);
    check_eq("t2_out_valid", out_valid, 0);

    // 3: sustained streaming, 100 beats with pointer wrap
    tick();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h100 + i, PKT ? 1'b1 : ((i % 3) == 2));
      @(negedge clock);
      if (i == 0) begin
        check_eq("t3_first_no_pop", out_valid, 0);
      end else begin
        check_eq($sformatf("t3_beat%0d", i - 1), out_beat(),
                 beat(32'h100 + i - 1, PKT ? 1'b1 : (((i - 1) % 3) == 2)));
        check_eq($sformatf("t3_fill%0d", i), fill_level, 1);
        check_eq($sformatf("t3_in_ready%0d", i), in_ready, 1);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t3_beat99", out_beat(), beat(32'h100 + 99, PKT ? 1'b1 : ((99 % 3) == 2)));
    tick();
    @(negedge clock);
    check_eq("t3_empty", empty, 1);

    // 4: reset with 5 beats held
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h50 + i, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t4_fill5", fill_level, 5);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check_eq("t4_rst_fill", fill_level, 0);
    check_eq("t4_rst_valid", out_valid, 0);
    check_eq("t4_rst_data", out_data, 0);
    check_eq("t4_rst_in_ready", in_ready, 0);
    tick();
    @(negedge clock);
    check_eq("t4_after_fill", fill_level, 0);
    check_eq("t4_after_empty", empty, 1);
    tick();
    reset = 1'b0;
    drive(1'b1, 32'hAA, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t4_aa_valid", out_valid, 1);
    check_eq("t4_aa_data", out_data, 32'hAA);
    check_eq("t4_aa_fill", fill_level, 1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clock);
    check_eq("t4_empty", empty, 1);
    tick();

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // 5: packet held until tlast, then streamed back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h60 + i, i == 2);
      @(negedge clock);
      check_eq($sformatf("t5_hold%0d", i), out_valid, 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("t5_valid%0d", i), out_valid, 1);
      check_eq($sformatf("t5_beat%0d", i), out_beat(), beat(32'h60 + i, i == 2));
      tick();
    end
    @(negedge clock);
    check_eq("t5_done", out_valid, 0);
    tick();

    // 6: full without tlast releases everything, then a lone tlast beat passes
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h70 + i, 1'b0);
      if (i == DEPTH - 1) begin
        @(negedge clock);
        check_eq("t6_hold_before_full", out_valid, 0);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t6_full", full, 1);
    check_eq("t6_release", out_valid, 1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      check_eq($sformatf("t6_valid%0d", i), out_valid, 1);
      check_eq($sformatf("t6_beat%0d", i), out_beat(), beat(32'h70 + i, 1'b0));
      tick();
    end
    @(negedge clock);
    check_eq("t6_empty", empty, 1);
    tick();
    drive(1'b1, 32'hEE, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    check_eq("t6_single_valid", out_valid, 1);
    check_eq("t6_single_beat", out_beat(), beat(32'hEE, 1'b1));
    tick();
    @(negedge clock);
    check_eq("t6_single_empty", empty, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
